// File: rtl/udp_tx_arb_if.sv
// Purpose: bundles the requester-side and downstream-side beat signals of udp_tx_arb.
// Ports:   requester lanes are packed per index (slice i at [i*W +: W]); downstream is a single lane.
// Modports: slave = arbiter view, master = environment view (requesters plus tx framer).
interface udp_tx_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W/8)
);
  // requester side
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_start_i;
  logic [N_REQ-1:0]        req_term_i;
  logic [N_REQ*LEN_W-1:0]  req_term_len_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*LEN_W-1:0]  req_len_i;
  logic [N_REQ-1:0]        req_ready_o;
  // downstream side
  logic                    ready_i;
  logic                    cancel_i;
  logic                    valid_o;
  logic                    start_o;
  logic                    term_o;
  logic [LEN_W-1:0]        term_len_o;
  logic [DATA_W-1:0]       data_o;
  logic [LEN_W-1:0]        len_o;
  logic [N_REQ-1:0]        grant_o;
  logic                    cancel_o;

  modport slave (
    input  req_valid_i, req_start_i, req_term_i, req_term_len_i, req_data_i, req_len_i,
    output req_ready_o,
    input  ready_i, cancel_i,
    output valid_o, start_o, term_o, term_len_o, data_o, len_o, grant_o, cancel_o
  );

  modport master (
    output req_valid_i, req_start_i, req_term_i, req_term_len_i, req_data_i, req_len_i,
    input  req_ready_o,
    output ready_i, cancel_i,
    input  valid_o, start_o, term_o, term_len_o, data_o, len_o, grant_o, cancel_o
  );
endinterface

// File: rtl/udp_tx_arb.sv
// Purpose: packet-granular round-robin arbiter sharing one UDP tx datapath among N_REQ requesters.
// Latency: grant registered 1 cycle after an eligible start beat; owner beats pass through with 0 latency.
// Backpressure: ready_i is forwarded only to the owner; owner idle for TIMEOUT cycles mid-packet is aborted.
// Ports: clk, reset (sync, active-high), bus (udp_tx_arb_if.slave) carrying all beat/handshake signals.
module udp_tx_arb #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = $clog2(DATA_W/8),
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  udp_tx_arb_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0] owner_q,  owner_d;
  logic [IDX_W-1:0] ptr_q,    ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             cancel_q, cancel_d;

  logic             busy;
  logic [N_REQ-1:0] elig;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] scan_idx;

  logic              own_vld, own_start, own_term;
  logic [DATA_W-1:0] own_data;
  logic [LEN_W-1:0]  own_len, own_term_len;
  logic              xfer_term, timeout, release_pkt;

  assign busy = (state_q == S_BUSY);
  assign elig = bus.req_valid_i & bus.req_start_i;

  // Round-robin pick: scanning downward means the last hit written is the
  // one closest to ptr_q, i.e. the first eligible index from ptr upward.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (elig[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  // Owner lane mux
  assign own_vld      = bus.req_valid_i[owner_q];
  assign own_start    = bus.req_start_i[owner_q];
  assign own_term     = bus.req_term_i[owner_q];
  assign own_data     = bus.req_data_i[int'(owner_q)*DATA_W +: DATA_W];
  assign own_len      = bus.req_len_i[int'(owner_q)*LEN_W +: LEN_W];
  assign own_term_len = bus.req_term_len_i[int'(owner_q)*LEN_W +: LEN_W];

  // The counter only advances while owner valid is low, so ready_i=0
  // (owner still valid) can never produce a timeout.
  assign timeout     = busy & ~own_vld & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign xfer_term   = busy & own_vld & bus.ready_i & own_term;
  assign release_pkt = busy & (xfer_term | bus.cancel_i | timeout);

  assign bus.valid_o     = busy & own_vld;
  assign bus.start_o     = busy & own_start;
  assign bus.term_o      = busy & own_term;
  assign bus.data_o      = busy ? own_data     : '0;
  assign bus.len_o       = busy ? own_len      : '0;
  assign bus.term_len_o  = busy ? own_term_len : '0;
  // grant_q is all-zero outside BUSY, so this also blocks consumption in IDLE
  assign bus.req_ready_o = grant_q & {N_REQ{bus.ready_i}};
  assign bus.grant_o     = grant_q;
  assign bus.cancel_o    = cancel_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = '0;
    cancel_d = timeout;
    if (!busy) begin
      if (sel_vld) begin
        state_d = S_BUSY;
        grant_d = N_REQ'(1) << sel_idx;
        owner_d = sel_idx;
      end
    end else if (release_pkt) begin
      // All release causes collapse into one release and one ptr advance
      state_d = S_IDLE;
      grant_d = '0;
      ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end else begin
      cnt_d = own_vld ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
    end
  end
endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares one UDP transmit datapath between N_REQ application requesters.
- Sits between the application layer and the UDP tx framer and uses the same valid/start/term/len beat format as the UDP rx path.
- Holds the grant from the start beat to the term beat of a packet.
- Recovers a stalled owner with a timeout abort, and honours a downstream cancel.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 16, beat data width in bits.
- LEN_W, $clog2(DATA_W/8), width of len/term_len fields.
- TIMEOUT, 64, number of consecutive owner-idle cycles mid-packet before a forced abort (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- req_valid_i  in  N_REQ  per-requester beat valid.
- req_start_i  in  N_REQ  per-requester first beat of packet.
- req_term_i  in  N_REQ  per-requester last beat of packet.
- req_term_len_i  in  N_REQ*LEN_W  per-requester term length, slice i at [i*LEN_W +: LEN_W].
- req_data_i  in  N_REQ*DATA_W  per-requester data, slice i at [i*DATA_W +: DATA_W].
- req_len_i  in  N_REQ*LEN_W  per-requester valid-byte length.
- req_ready_o  out  N_REQ  beat accepted from requester i this cycle.
- ready_i  in  1  downstream can accept a beat.
- cancel_i  in  1  downstream aborts the current packet.
- valid_o  out  1  beat valid to the tx datapath.
- start_o  out  1  first beat.
- term_o  out  1  last beat.
- term_len_o  out  LEN_W  term length.
- data_o  out  DATA_W  data.
- len_o  out  LEN_W  valid-byte length.
- grant_o  out  N_REQ  one-hot current owner; all zero when IDLE.
- cancel_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - FSM=IDLE, grant=0, rr pointer=0, idle counter=0, cancel_o=0.
  - Outputs settle the cycle after reset is sampled: valid_o=0, req_ready_o=0, data_o/len_o/term_len_o=0.
  - A packet in flight is dropped silently, with no cancel_o.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Eligible requesters are those with req_valid_i[i] & req_start_i[i].
  - Selection: the first eligible index scanning from ptr upward, with wrap-around.
  - If any requester is eligible: next state BUSY and grant_o = one-hot(selected), both registered. Grant latency is 1 cycle.
  - No beat is consumed in IDLE; req_ready_o=0.
  - A valid beat without start is never eligible and stalls until the grant is released.
- BUSY with owner o:
  - valid_o=req_valid_i[o], and start/term/data/len/term_len are muxed combinationally from o (zero-latency passthrough).
  - req_ready_o[o]=ready_i; all other req_ready_o bits are 0.
  - A transfer is valid_o & ready_i.
  - Start beats from the owner mid-packet are forwarded unchanged and not checked.
- Release (BUSY→IDLE next cycle, ptr←(o+1) mod N_REQ, grant←0) on any of:
  - a transfer with term_o=1;
  - cancel_i=1;
  - timeout.
  - Simultaneous release causes release once, with a single ptr advance.
  - A one-cycle IDLE bubble always separates packets.
- Idle counter, width $clog2(TIMEOUT+1):
  - Cleared in IDLE and on every BUSY cycle where req_valid_i[o]=1, regardless of ready_i.
  - Otherwise increments.
  - When it reaches TIMEOUT-1 and owner valid is still low, a timeout occurs: cancel_o=1 in the cycle after that, concurrent with the return to IDLE.
  - Backpressure (ready_i=0) never triggers a timeout.
- cancel_i during IDLE is ignored.
- cancel_i in the same cycle as a timeout: release once, cancel_o still pulses.
- Fairness: under continuous demand from all requesters, packets are granted in strict rotation 0,1,…,N_REQ-1,0.

Test Plan:
- Single requester: req1 sends a 3-beat packet, start at t0 with ready_i=1 → grant_o=2'b10 at t1; valid_o at t1..t3 with data equal to req1 beats; term at t3; grant_o=0 at t4; ptr=0.
- Contention: both requesters present start at t0 with ptr=0 → req0 granted first. After req0's term, req1 is granted 2 cycles after that term beat. A third round gives req0 again.
- Backpressure: ready_i=0 for 100 cycles mid-packet while owner valid=1 → no timeout, no cancel_o; req_ready_o[owner]=0 for that period; packet completes once ready_i returns.
- Timeout with TIMEOUT=4: owner drops valid after its start beat → cancel_o pulses exactly once, 5 cycles after the last valid cycle; grant released; ptr advanced; the other requester is granted next.
- Cancel_i: asserted on a non-term beat of req0 → IDLE the next cycle, no cancel_o pulse; a pending req1 start is granted 1 cycle later.
- Reset mid-packet: reset asserted while BUSY → the cycle after reset is sampled: grant_o=0, valid_o=0, req_ready_o=0, cancel_o=0; the next arbitration starts from req0.
